dds_addr_gen: RTL and testbench

- Phase-accumulator address generator that drives the 1024x16 sine lookup (ROM with `clka`/`addra[9:0]`/`douta[15:0]` and a 2-cycle enable-to-valid wrapper).
- It is the initiator side of that interface: issues one address per cycle for a burst, tracks outstanding lookups, and forwards the returned samples.
- Signals burst completion once every issued sample has come back.

---
 rtl/dds_addr_gen.sv | 152 +++++++++++++++
 tb/tb_dds_addr_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_addr_gen.sv
// dds_addr_gen: phase-accumulator address generator for a 1024x16 sine lookup.
//
// Issues one lookup address per cycle for a burst of i_nsamp samples
// (0 = continuous until i_stop). It tracks lookups in flight, forwards returned
// samples, and pulses o_done once every issued sample has come back.
//
// Optional build macro DDS_PHASE_OFFSET_EN adds i_phase. This is the starting
// phase, latched on start.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    synchronous active-low reset
//   i_start    burst start pulse (sampled in IDLE only)
//   i_stop     abort request (sampled in RUN only)
//   i_ftw      frequency tuning word, latched on start
//   i_nsamp    burst length, latched on start; 0 = continuous
//   i_phase    start phase (DDS_PHASE_OFFSET_EN builds only)
//   o_busy     high in RUN or DRAIN
//   o_addr     lookup address
//   o_en       lookup request, one per address
//   i_sin      returned sample
//   i_sin_vld  returned sample valid, 2 cycles after the matching o_en
//   o_data     forwarded sample
//   o_vld      o_data valid
//   o_done     one-cycle end-of-burst pulse
//   o_err      sticky: sample returned with nothing outstanding
module dds_addr_gen #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ACC_W-1:0]  i_ftw,
  input  logic [CNT_W-1:0]  i_nsamp,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]  i_phase,
`endif
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_en,
  input  logic [DATA_W-1:0] i_sin,
  input  logic              i_sin_vld,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_lat;
  logic [CNT_W-1:0] nsamp_lat;
  logic [CNT_W-1:0] issued;
  logic [1:0]       outstanding;

  logic [ACC_W-1:0] acc_init;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] issued_inc;
  logic             last_issue;
  logic             accepted;
  logic [1:0]       out_next;

`ifdef DDS_PHASE_OFFSET_EN
  assign acc_init = i_phase;
`else
  assign acc_init = '0;
`endif

  assign acc_sum    = acc + ftw_lat;
  assign issued_inc = issued + CNT_W'(1);
  // The address currently on the bus is the final one of a finite burst.
  assign last_issue = (nsamp_lat != '0) && (issued_inc == nsamp_lat);
  assign accepted   = i_sin_vld && (outstanding != 2'd0);
  // An issue and a return in the same cycle cancel out.
  assign out_next   = outstanding + 2'(o_en) - 2'(accepted);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= StIdle;
      acc         <= '0;
      ftw_lat     <= '0;
      nsamp_lat   <= '0;
      issued      <= '0;
      outstanding <= '0;
      o_busy      <= 1'b0;
      o_addr      <= '0;
      o_en        <= 1'b0;
      o_data      <= '0;
      o_vld       <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      outstanding <= out_next;
      o_vld       <= accepted;
      o_done      <= 1'b0;
      if (accepted) begin
        o_data <= i_sin;
      end
      if (i_sin_vld && !accepted) begin
        o_err <= 1'b1;
      end

      case (state)
        StIdle: begin
          // A stop arriving together with start is ignored here.
          if (i_start) begin
            ftw_lat   <= i_ftw;
            nsamp_lat <= i_nsamp;
            acc       <= acc_init;
            issued    <= '0;
            o_addr    <= acc_init[ACC_W-1 -: ADDR_W];
            o_en      <= 1'b1;
            o_busy    <= 1'b1;
            state     <= StRun;
          end
        end
        StRun: begin
          // o_en is always high in RUN, so every RUN cycle is one issue.
          acc    <= acc_sum;
          o_addr <= acc_sum[ACC_W-1 -: ADDR_W];
          if (issued != '1) begin
            issued <= issued_inc;
          end
          if (last_issue || i_stop) begin
            o_en  <= 1'b0;
            state <= StDrain;
          end
        end
        StDrain: begin
          // o_done is raised with the last o_vld; the FSM leaves DRAIN one
          // cycle later so that o_busy covers the o_done cycle.
          if (o_done) begin
            o_busy <= 1'b0;
            state  <= StIdle;
          end else if (out_next == 2'd0) begin
            o_done <= 1'b1;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_addr_gen.sv
module tb_dds_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] ftw = '0;
  logic [15:0] nsamp = '0;
  logic        busy;
  logic [9:0]  addr;
  logic        en;
  logic [15:0] sin;
  logic        sin_vld;
  logic [15:0] data;
  logic        vld;
  logic        done;
  logic        err;

  logic        inj_vld = 1'b0;
  logic [15:0] inj_data = '0;
  logic        p1_en = 1'b0, p2_en = 1'b0;
  logic [9:0]  p1_a = '0, p2_a = '0;

  int n_tests = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  dds_addr_gen dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_stop    (stop),
    .i_ftw     (ftw),
    .i_nsamp   (nsamp),
    .o_busy    (busy),
    .o_addr    (addr),
    .o_en      (en),
    .i_sin     (sin),
    .i_sin_vld (sin_vld),
    .o_data    (data),
    .o_vld     (vld),
    .o_done    (done),
    .o_err     (err)
  );

  // Sine lookup model: arbitrary but address-unique contents, 2-cycle latency.
  function automatic logic [15:0] rom_f(input logic [9:0] a);
    return 16'h5A00 ^ {a, 6'd0} ^ {6'd0, a};
  endfunction

  always @(posedge clk) begin
    p1_en <= en;
    p1_a  <= addr;
    p2_en <= p1_en;
    p2_a  <= p1_a;
  end

  assign sin_vld = p2_en | inj_vld;
  assign sin     = p2_en ? rom_f(p2_a) : inj_data;

  // Burst capture results
  int          en_cnt, vld_cnt, done_cnt, first_en, first_vld, done_cyc;
  logic        done_vld, busy_at_done, busy_after, busy_first;
  logic [9:0]  got_addr [32];
  logic [15:0] got_data [32];

  task automatic kick(input logic [31:0] f, input logic [15:0] n, input logic stp);
    @(posedge clk); #1;
    ftw = f; nsamp = n; start = 1'b1; stop = stp;
  endtask

  // Records outputs cycle by cycle after a kick; optionally raises stop or a
  // spurious start (with different ftw/nsamp) on a given cycle.
  task automatic capture(input int max_cyc, input int stop_cyc, input int pulse_cyc);
    en_cnt = 0; vld_cnt = 0; done_cnt = 0; first_en = -1; first_vld = -1;
    done_cyc = -1; done_vld = 1'b0; busy_at_done = 1'b0; busy_after = 1'bx;
    busy_first = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      if (cyc == 1) busy_first = busy;
      if (en) begin
        if (en_cnt < 32) got_addr[en_cnt] = addr;
        if (first_en < 0) first_en = cyc;
        en_cnt++;
      end
      if (vld) begin
        if (vld_cnt < 32) got_data[vld_cnt] = data;
        if (first_vld < 0) first_vld = cyc;
        vld_cnt++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        if (done) done_cnt++;
        break;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; done_vld = vld; busy_at_done = busy;
      end
      if (cyc == stop_cyc) stop = 1'b1;
      if (cyc == pulse_cyc) begin
        start = 1'b1; ftw = 32'h1000_0000; nsamp = 16'd2;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, addr, en, data, vld, done, err} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b addr=%0d en=%b data=%h vld=%b done=%b err=%b, want all 0",
               busy, addr, en, data, vld, done, err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, en, vld, done, err} !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b en=%b vld=%b done=%b err=%b, want 0",
               busy, en, vld, done, err);
    end
  endtask

  task automatic test_basic;
    kick(32'h0040_0000, 16'd4, 1'b0);
    capture(40, -1, -1);
    n_tests++;
    if (en_cnt !== 4) begin n_fail++; $display("FAIL basic_en_count: got %0d want 4", en_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_addr[i] !== 10'(i)) begin
        n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, got_addr[i], i);
      end
      n_tests++;
      if (got_data[i] !== rom_f(10'(i))) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_data[i], rom_f(10'(i)));
      end
    end
    n_tests++;
    if (first_en !== 1 || first_vld !== 4 || vld_cnt !== 4) begin
      n_fail++;
      $display("FAIL basic_timing: got first_en=%0d first_vld=%0d vld_cnt=%0d want 1 4 4",
               first_en, first_vld, vld_cnt);
    end
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 7 || done_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got cnt=%0d cyc=%0d vld=%b want 1 7 1", done_cnt, done_cyc, done_vld);
    end
    n_tests++;
    if (busy_first !== 1'b1 || busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got first=%b at_done=%b after=%b want 1 1 0",
               busy_first, busy_at_done, busy_after);
    end
  endtask

  task automatic test_step8;
    kick(32'h0100_0000, 16'd8, 1'b0);
    capture(60, -1, -1);
    n_tests++;
    if (en_cnt !== 8 || vld_cnt !== 8 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL step8_counts: got en=%0d vld=%0d done=%0d want 8 8 1", en_cnt, vld_cnt, done_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got_addr[i] !== 10'(4 * i) || got_data[i] !== rom_f(10'(4 * i))) begin
        n_fail++;
        $display("FAIL step8_addr[%0d]: got addr=%0d data=%h want addr=%0d", i, got_addr[i],
                 got_data[i], 4 * i);
      end
    end
  endtask

  task automatic test_wrap;
    logic [9:0] exp_a [3];
    exp_a[0] = 10'd0; exp_a[1] = 10'd512; exp_a[2] = 10'd0;
    kick(32'h8000_0000, 16'd3, 1'b0);
    capture(40, -1, -1);
    n_tests++;
    if (en_cnt !== 3 || vld_cnt !== 3 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL wrap_counts: got en=%0d vld=%0d done=%0d want 3 3 1", en_cnt, vld_cnt, done_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (got_addr[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, got_addr[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_stop;
    kick(32'h0040_0000, 16'd0, 1'b0);
    capture(60, 5, -1);
    n_tests++;
    if (en_cnt !== 5 || vld_cnt !== 5) begin
      n_fail++; $display("FAIL stop_counts: got en=%0d vld=%0d want 5 5", en_cnt, vld_cnt);
    end
    n_tests++;
    if (got_addr[4] !== 10'd4) begin
      n_fail++; $display("FAIL stop_last_addr: got %0d want 4", got_addr[4]);
    end
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 8 || done_vld !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_done: got cnt=%0d cyc=%0d vld=%b busy_after=%b want 1 8 1 0",
               done_cnt, done_cyc, done_vld, busy_after);
    end
  endtask

  task automatic test_start_stop_idle;
    kick(32'h0080_0000, 16'd3, 1'b1);
    capture(40, -1, -1);
    n_tests++;
    if (en_cnt !== 3 || vld_cnt !== 3 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL startstop_counts: got en=%0d vld=%0d done=%0d want 3 3 1", en_cnt, vld_cnt, done_cnt);
    end
    n_tests++;
    if (got_addr[0] !== 10'd0 || got_addr[1] !== 10'd2 || got_addr[2] !== 10'd4) begin
      n_fail++;
      $display("FAIL startstop_addr: got %0d,%0d,%0d want 0,2,4", got_addr[0], got_addr[1], got_addr[2]);
    end
  endtask

  task automatic test_restart_ignored;
    kick(32'h0040_0000, 16'd6, 1'b0);
    capture(50, -1, 3);
    n_tests++;
    if (en_cnt !== 6 || vld_cnt !== 6 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL restart_counts: got en=%0d vld=%0d done=%0d want 6 6 1", en_cnt, vld_cnt, done_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (got_addr[i] !== 10'(i)) begin
        n_fail++; $display("FAIL restart_addr[%0d]: got %0d want %0d", i, got_addr[i], i);
      end
    end
  endtask

  task automatic test_err_idle;
    @(posedge clk); #1;
    inj_vld = 1'b1; inj_data = 16'hBEEF;
    @(posedge clk); #1;
    inj_vld = 1'b0;
    n_tests++;
    if (err !== 1'b1 || vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL err_set: got err=%b vld=%b busy=%b want 1 0 0", err, vld, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1", err);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_reset_clear: got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid_burst;
    kick(32'h0040_0000, 16'd8, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if ({busy, addr, en, data, vld, done, err} !== 31'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b addr=%0d en=%b data=%h vld=%b done=%b err=%b, want all 0",
               busy, addr, en, data, vld, done, err);
    end
    @(posedge clk); #1;
    n_tests++;
    if (err !== 1'b1 || vld !== 1'b0 || en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_late_return: got err=%b vld=%b en=%b busy=%b want 1 0 0 0",
               err, vld, en, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (err !== 1'b1 || vld !== 1'b0) begin
      n_fail++; $display("FAIL midreset_second_return: got err=%b vld=%b want 1 0", err, vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step8();
    test_wrap();
    test_stop();
    test_start_stop_idle();
    test_restart_ignored();
    test_err_idle();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
